// File: rtl/int_mul_pipe.sv
// int_mul_pipe: parametrised, fully pipelined RISC-V M-extension multiplier.
// The multiplier accepts one op per cycle and carries a tag with each op to
// the output. A valid/ready handshake stalls the whole pipe under backpressure.
// The partial products are reduced in carry-save form across the stages.
// The last stage does the single carry-propagate add and selects the result bits.
// All state changes on the falling edge of clk.
// Optional feature: define INT_MUL_FLUSH_EN to add flush_i. A flush clears
// every in-flight op.
module int_mul_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef INT_MUL_FLUSH_EN
   input  logic             flush_i,
`endif
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       op_i,
   input  logic [XLEN-1:0]  a_i,
   input  logic [XLEN-1:0]  b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             busy_o
);

   // Signed product width and number of partial-product rows (one per bit of extended b)
   localparam int unsigned PW   = 2 * XLEN + 2;
   localparam int unsigned ROWS = XLEN + 1;
   // Rows reduced per stage; never exceeds ceil(XLEN/STAGES)+1
   localparam int unsigned RPS  = (ROWS + STAGES - 1) / STAGES;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   // Pipeline stage registers; index STAGES-1 is the output stage
   logic [STAGES-1:0] valid_q;
   logic [PW-1:0]     sum_q   [STAGES];
   logic [PW-1:0]     carry_q [STAGES];
   logic [PW-1:0]     a_q     [STAGES];
   logic [XLEN:0]     b_q     [STAGES];
   logic [1:0]        op_q    [STAGES];
   logic [TAG_W-1:0]  tag_q   [STAGES];
   logic [XLEN-1:0]   result_q;
   logic [TAG_W-1:0]  tag_out_q;

   // Per-stage sources (previous stage register, or the inputs for stage 0)
   logic [STAGES-1:0] valid_d;
   logic [PW-1:0]     src_a     [STAGES];
   logic [XLEN:0]     src_b     [STAGES];
   logic [PW-1:0]     src_sum   [STAGES];
   logic [PW-1:0]     src_carry [STAGES];
   logic [1:0]        src_op    [STAGES];
   logic [TAG_W-1:0]  src_tag   [STAGES];
   logic [PW-1:0]     sum_d     [STAGES];
   logic [PW-1:0]     carry_d   [STAGES];
   logic [PW-1:0]     product_c;
   logic [XLEN-1:0]   result_d;

   logic stall_c;
   logic flush_c;
   logic a_sgn_c;
   logic b_sgn_c;

`ifdef INT_MUL_FLUSH_EN
   assign flush_c = flush_i;
`else
   assign flush_c = 1'b0;
`endif

   // Global stall: the output stage is full and is not being consumed
   assign stall_c     = valid_q[STAGES-1] & ~out_ready_i;
   assign in_ready_o  = ~stall_c & ~flush_c;
   assign out_valid_o = valid_q[STAGES-1];
   assign busy_o      = |valid_q;
   assign result_o    = result_q;
   assign tag_o       = tag_out_q;

   // Operand extension for stage 0 and source selection for the later stages
   always_comb begin
      a_sgn_c      = (op_i == OP_MULH) || (op_i == OP_MULHSU);
      b_sgn_c      = (op_i == OP_MULH);
      src_a[0]     = {{(XLEN + 2){a_sgn_c & a_i[XLEN-1]}}, a_i};
      src_b[0]     = {b_sgn_c & b_i[XLEN-1], b_i};
      src_sum[0]   = '0;
      // +1 that completes the two's-complement negation of the top row
      src_carry[0] = PW'(b_sgn_c & b_i[XLEN-1]);
      src_op[0]    = op_i;
      src_tag[0]   = tag_i;
      valid_d[0]   = in_valid_i & in_ready_o;
      for (int unsigned s = 1; s < STAGES; s++) begin
         src_a[s]     = a_q[s-1];
         src_b[s]     = b_q[s-1];
         src_sum[s]   = sum_q[s-1];
         src_carry[s] = carry_q[s-1];
         src_op[s]    = op_q[s-1];
         src_tag[s]   = tag_q[s-1];
         valid_d[s]   = valid_q[s-1];
      end
   end

   // Carry-save reduction of this stage's share of rows, then the final add and select
   always_comb begin : reduce
      logic [PW-1:0] row;
      logic [PW-1:0] s_tmp;
      row       = '0;
      s_tmp     = '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         sum_d[s]   = src_sum[s];
         carry_d[s] = src_carry[s];
         for (int unsigned j = 0; j < ROWS; j++) begin
            if ((j / RPS) == s) begin
               row = '0;
               if (src_b[s][j]) begin
                  // The top bit of extended b carries negative weight
                  row = (j == XLEN) ? ~(src_a[s] << j) : (src_a[s] << j);
               end
               s_tmp      = sum_d[s] ^ carry_d[s] ^ row;
               carry_d[s] = ((sum_d[s] & carry_d[s]) | (sum_d[s] & row) |
                             (carry_d[s] & row)) << 1;
               sum_d[s]   = s_tmp;
            end
         end
      end
      product_c = sum_d[STAGES-1] + carry_d[STAGES-1];
      result_d  = (src_op[STAGES-1] == OP_MUL) ? XLEN'(product_c) : XLEN'(product_c >> XLEN);
   end

   // Control and output stage: valid bits, result and tag (reset and flush apply here)
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         valid_q   <= '0;
         result_q  <= '0;
         tag_out_q <= '0;
      end else if (flush_c) begin
         valid_q <= '0;
      end else if (!stall_c) begin
         valid_q <= valid_d;
         if (valid_d[STAGES-1]) begin
            result_q  <= result_d;
            tag_out_q <= src_tag[STAGES-1];
         end
      end
   end

   // Datapath registers advance whenever the pipe moves; their contents are ignored while invalid
   always_ff @(negedge clk) begin
      if (!flush_c && !stall_c) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            sum_q[s]   <= sum_d[s];
            carry_q[s] <= carry_d[s];
            a_q[s]     <= src_a[s];
            b_q[s]     <= src_b[s];
            op_q[s]    <= src_op[s];
            tag_q[s]   <= src_tag[s];
         end
      end
   end

endmodule

// File: tb/tb_int_mul_pipe.sv
// Scoreboard bench for int_mul_pipe (XLEN=32, STAGES=4). The DUT updates on falling edges.
// The bench drives inputs 1 time unit after each rising edge and samples 2 units after it.
module tb_int_mul_pipe;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned STAGES = 4;
   localparam int unsigned TAG_W  = 5;

   localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

   logic             clk;
   logic             rst_n;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [1:0]       op_i;
   logic [XLEN-1:0]  a_i;
   logic [XLEN-1:0]  b_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;
   logic             busy_o;
`ifdef INT_MUL_FLUSH_EN
   logic             flush_i;
`endif

   int_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef INT_MUL_FLUSH_EN
      .flush_i     (flush_i),
`endif
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .result_o    (result_o),
      .tag_o       (tag_o),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   int               n_checks = 0;
   int               n_fail   = 0;
   int               n_deliv  = 0;
   int               deliv_base;
   bit               hold_q   = 1'b0;
   logic [XLEN-1:0]  hold_res;
   logic [TAG_W-1:0] hold_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pop and compare on each handshake; output must be stable while stalled
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q && out_valid_o) begin
            check("hold_result", 64'(result_o), 64'(hold_res));
            check("hold_tag", 64'(tag_o), 64'(hold_tag));
         end
         hold_q = 1'b0;
         if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got result 0x%0h tag %0d, required no result (t=%0t)",
                        result_o, tag_o, $time);
            end else begin
               mon_e = sb.pop_front();
               check("result", 64'(result_o), 64'(mon_e.res));
               check("tag", 64'(tag_o), 64'(mon_e.tag));
               n_deliv++;
            end
         end else if (out_valid_o) begin
            hold_q   = 1'b1;
            hold_res = result_o;
            hold_tag = tag_o;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op and wait (bounded) for it to be accepted; returns just after the accepting edge
   task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp);
      exp_t e;
      in_valid_i = 1'b1;
      op_i       = op;
      a_i        = a;
      b_i        = b;
      tag_i      = tag;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (in_ready_o) begin
            e.res = exp;
            e.tag = tag;
            sb.push_back(e);
            tick();
            return;
         end
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: tag %0d not accepted in 50 cycles, required acceptance", tag);
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Backpressure: hold out_ready low for 3 cycles once the first result shows up
   task automatic stall_window();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         if (out_valid_o) seen = 1'b1;
      end
      check("stall_first_result_seen", 64'(seen), 64'd1);
      if (seen) begin
         out_ready_i = 1'b0;
         for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 64'(in_ready_o), 64'd0);
            @(posedge clk);
            #1;
         end
         out_ready_i = 1'b1;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid_i  = 1'b0;
      op_i        = MUL;
      a_i         = '0;
      b_i         = '0;
      tag_i       = '0;
      out_ready_i = 1'b1;
`ifdef INT_MUL_FLUSH_EN
      flush_i     = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_result", 64'(result_o), 64'd0);
      check("rst_tag", 64'(tag_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      tick();

      // Latency: 7*6 appears after exactly STAGES edges counting the accept edge
      issue(MUL, 32'd7, 32'd6, 5'd3, 32'h0000_002A);
      in_valid_i = 1'b0;
      for (int k = 1; k <= int'(STAGES); k++) begin
         #1;
         check("latency_valid", 64'(out_valid_o), (k == int'(STAGES)) ? 64'd1 : 64'd0);
         @(posedge clk);
         #1;
      end

      // All-ones operands, back-to-back, four consecutive results
      issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
      issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
      issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
      issue(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
      in_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("b2b_valid", 64'(out_valid_o), (i < 4) ? 64'd1 : 64'd0);
         @(posedge clk);
         #1;
      end

      // Most-negative operand corners and a few mixed-sign vectors
      issue(MULH,   32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000);
      issue(MULHU,  32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
      issue(MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000);
      issue(MUL,    32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFE);
      issue(MULHU,  32'hFFFF_FFFF, 32'd2,         5'd9,  32'h0000_0001);
      issue(MULH,   32'hFFFF_FFFF, 32'd2,         5'd10, 32'hFFFF_FFFF);
      issue(MULHSU, 32'd2,         32'hFFFF_FFFF, 5'd11, 32'h0000_0001);
      issue(MUL,    32'h1234_5678, 32'h10,        5'd12, 32'h2345_6780);
      in_valid_i = 1'b0;
      drain();

      // Six ops with a 3-cycle backpressure window; all tags in order, no loss
      deliv_base = n_deliv;
      fork
         begin
            for (int t = 0; t < 6; t++) begin
               issue(MUL, 32'(t + 1), 32'd3, 5'(t), 32'(3 * (t + 1)));
            end
            in_valid_i = 1'b0;
         end
         stall_window();
      join
      drain();
      check("stall_delivered", 64'(n_deliv - deliv_base), 64'd6);

      // Reset with two ops in flight discards both
      issue(MUL, 32'd9, 32'd9, 5'd20, 32'd81);
      issue(MUL, 32'd8, 32'd8, 5'd21, 32'd64);
      in_valid_i = 1'b0;
      check("busy_inflight", 64'(busy_o), 64'd1);
      rst_n = 1'b0;
      sb.delete();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_mid_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_mid_busy", 64'(busy_o), 64'd0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #2;
         check("rst_mid_quiet", 64'(out_valid_o), 64'd0);
      end
      tick();

`ifdef INT_MUL_FLUSH_EN
      // Flush with three ops in flight and a same-cycle request: nothing emerges
      issue(MUL, 32'd2, 32'd2, 5'd22, 32'd4);
      issue(MUL, 32'd3, 32'd3, 5'd23, 32'd9);
      issue(MUL, 32'd4, 32'd4, 5'd24, 32'd16);
      in_valid_i = 1'b1;
      a_i        = 32'd11;
      b_i        = 32'd11;
      tag_i      = 5'd25;
      flush_i    = 1'b1;
      sb.delete();
      #1;
      check("flush_in_ready", 64'(in_ready_o), 64'd0);
      @(posedge clk);
      #1;
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid_o), 64'd0);
      check("flush_busy", 64'(busy_o), 64'd0);
      @(posedge clk);
      #1;
      issue(MUL, 32'd3, 32'd5, 5'd26, 32'h0000_000F);
      in_valid_i = 1'b0;
      for (int k = 1; k <= int'(STAGES); k++) begin
         #1;
         check("flush_latency_valid", 64'(out_valid_o), (k == int'(STAGES)) ? 64'd1 : 64'd0);
         @(posedge clk);
         #1;
      end
      drain();
`endif

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
